// File: rtl/vga_rx_monitor.sv
// Recovers pixel position and timing lock from a sampled VGA stream (hsync/vsync/RGB444),
// qualified by a pixel-rate strobe in the system clock domain.
module vga_rx_monitor #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pix_ce,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [11:0] vga_rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_VIS_LO = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_VIS_HI = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_VIS_LO = 10'(V_SYNC + V_BACK);
    localparam logic [9:0]  V_VIS_HI = 10'(V_SYNC + V_BACK + V_ACTIVE);

    typedef enum logic [1:0] {SEEK, CHECK, LOCKED} state_t;

    state_t      state, state_nx;
    logic        hs_prev_p0, vs_prev_p0;
    logic [10:0] h_cnt_p0, h_cnt_nx;
    logic [9:0]  v_cnt_p0, v_cnt_nx;
    logic        armed_p0, armed_nx;
    logic        hs_seen_p0;
    logic        hs_fall, vs_fall, boundary, checking;
    logic        line_err, frame_err, visible;

    function automatic logic [10:0] sat_inc_h(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] sat_inc_v(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    always_comb begin
        hs_fall   = hs_prev_p0 & ~vga_hs;
        vs_fall   = vs_prev_p0 & ~vga_vs;
        // a vsync fall arms the boundary; the same sample's hsync fall may consume it
        armed_nx  = armed_p0 | vs_fall;
        boundary  = hs_fall & armed_nx;
        if (boundary) armed_nx = 1'b0;
        checking  = (state == CHECK) || (state == LOCKED);
        line_err  = checking & hs_fall & hs_seen_p0 & (h_cnt_p0 != H_LAST);
        frame_err = checking & boundary & (v_cnt_p0 != V_LAST);
        h_cnt_nx  = hs_fall ? 11'd0 : sat_inc_h(h_cnt_p0);
        v_cnt_nx  = v_cnt_p0;
        if (boundary)     v_cnt_nx = 10'd0;
        else if (hs_fall) v_cnt_nx = sat_inc_v(v_cnt_p0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEEK:    if (boundary) state_nx = CHECK;
            CHECK: begin
                if (line_err || frame_err) state_nx = SEEK;
                else if (boundary)         state_nx = LOCKED;
            end
            LOCKED:  if (line_err || frame_err) state_nx = SEEK;
            default: state_nx = SEEK;
        endcase
    end

    // leaving LOCKED on this sample suppresses its pixel
    always_comb begin
        visible = (state == LOCKED) && (state_nx == LOCKED) &&
                  (h_cnt_nx >= H_VIS_LO) && (h_cnt_nx < H_VIS_HI) &&
                  (v_cnt_nx >= V_VIS_LO) && (v_cnt_nx < V_VIS_HI);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst)     state <= SEEK;
        else if (pix_ce) state <= state_nx;
    end

    // stage p0: previous-sample and counter state
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hs_prev_p0 <= 1'b1;
            vs_prev_p0 <= 1'b1;
            h_cnt_p0   <= '0;
            v_cnt_p0   <= '0;
            armed_p0   <= 1'b0;
            hs_seen_p0 <= 1'b0;
        end else if (pix_ce) begin
            hs_prev_p0 <= vga_hs;
            vs_prev_p0 <= vga_vs;
            h_cnt_p0   <= h_cnt_nx;
            v_cnt_p0   <= v_cnt_nx;
            armed_p0   <= armed_nx;
            hs_seen_p0 <= hs_seen_p0 | hs_fall;
        end
    end

    // stage p1: registered outputs, one cycle after the sample
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            if (pix_ce) begin
                pix_valid <= visible;
                if (visible) begin
                    pix_x   <= 10'(h_cnt_nx - H_VIS_LO);
                    pix_y   <= v_cnt_nx - V_VIS_LO;
                    pix_rgb <= vga_rgb;
                end
                if (boundary && (state_nx == LOCKED)) begin
                    frame_start <= 1'b1;
                    frame_cnt   <= frame_cnt + 16'd1;
                end
                locked <= (state_nx == LOCKED);
                h_err  <= line_err;
                v_err  <= frame_err;
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor: a small-raster video generator drives samples, a pixel
// scoreboard checks recovered pixels, and per-sample flag records check lock/error/frame behaviour.
module tb_vga_rx_monitor;

    localparam int HS = 4, HB = 3, HA = 8, HT = 20;
    localparam int VS = 2, VB = 2, VA = 5, VT = 12;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic        pix_ce  = 1'b0;
    logic        vga_hs  = 1'b1;
    logic        vga_vs  = 1'b1;
    logic [11:0] vga_rgb = '0;
    logic        pix_valid, frame_start, locked, h_err, v_err;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_cnt;

    vga_rx_monitor #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .pix_ce(pix_ce),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_rgb(vga_rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .locked(locked), .h_err(h_err), .v_err(v_err),
        .frame_cnt(frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    // one generated frame: line count, short line, start/abort points, expected boundary flags
    typedef struct {
        int nlines;
        int short_line;
        int v0, h0;
        int abort_v, abort_h;
        bit fs, lock, verr, const_rgb, irregular;
    } frame_t;

    pix_t        exp_q[$];
    pix_t        last_exp;
    int          checks = 0;
    int          errors = 0;
    int          pop_cnt = 0;
    bit          mon_en = 1'b0;
    logic [15:0] exp_fc = '0;
    logic        rst_q = 1'b0;
    logic        ce_q = 1'b0;

    always @(posedge sys_clk) begin
        rst_q <= sys_rst;
        ce_q  <= pix_ce;
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        pix_t p;
        forever begin
            @(negedge sys_clk);
            if (mon_en) begin
                if (rst_q) begin
                    last_exp = '0;
                    chk("rst_flags", 32'({pix_valid, frame_start, locked, h_err, v_err}), 32'd0);
                    chk("rst_pix", {pix_x, pix_y, pix_rgb}, 32'd0);
                    chk("rst_fcnt", 32'(frame_cnt), 32'd0);
                end else begin
                    if (pix_valid) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL pix_valid: unexpected pulse x=%0d y=%0d, expected none", pix_x, pix_y);
                        end else begin
                            p = exp_q.pop_front();
                            chk("pixel", {pix_x, pix_y, pix_rgb}, p);
                            last_exp = p;
                            pop_cnt++;
                        end
                    end else begin
                        chk("hold", {pix_x, pix_y, pix_rgb}, last_exp);
                    end
                    if (!ce_q)
                        chk("idle_pulses", 32'({pix_valid, frame_start, h_err, v_err}), 32'd0);
                end
            end
        end
    endtask

    task automatic sample(input logic hs, input logic vs, input logic [11:0] rgb, input int idle);
        repeat (idle - 1) @(negedge sys_clk);
        @(negedge sys_clk);
        pix_ce  = 1'b1;
        vga_hs  = hs;
        vga_vs  = vs;
        vga_rgb = rgb;
        @(negedge sys_clk);
        pix_ce  = 1'b0;
        vga_hs  = 1'($urandom);
        vga_vs  = 1'($urandom);
        vga_rgb = 12'($urandom);
    endtask

    task automatic send_frame(input frame_t f);
        bit cur_lock;
        cur_lock = f.lock;
        pop_cnt  = 0;
        for (int vc = f.v0; vc < f.nlines; vc++) begin
            int len;
            len = (vc == f.short_line) ? HT - 1 : HT;
            for (int hc = (vc == f.v0) ? f.h0 : 0; hc < len; hc++) begin
                logic [11:0] rgb;
                bit is_bnd, he, vis;
                pix_t p;
                if (vc == f.abort_v && hc == f.abort_h) return;
                rgb    = f.const_rgb ? 12'hA5C : 12'($urandom);
                is_bnd = (vc == 0) && (hc == 0);
                he     = (f.short_line >= 0) && (vc == f.short_line + 1) && (hc == 0);
                if (he) cur_lock = 1'b0;
                vis = cur_lock && (hc >= HS + HB) && (hc < HS + HB + HA) &&
                      (vc >= VS + VB) && (vc < VS + VB + VA);
                if (vis) begin
                    p.x   = 10'(hc - HS - HB);
                    p.y   = 10'(vc - VS - VB);
                    p.rgb = rgb;
                    exp_q.push_back(p);
                end
                if (is_bnd && f.fs) exp_fc++;
                sample(1'(hc >= HS), 1'(vc >= VS), rgb,
                       f.irregular ? int'($urandom_range(7, 1)) : 3);
                chk("flags{fs,herr,verr,lock}", 32'({frame_start, h_err, v_err, locked}),
                    32'({is_bnd && f.fs, he, is_bnd && f.verr, cur_lock}));
                chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
            end
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        if (f.lock && f.short_line < 0 && f.v0 == 0)
            chk("pix_count", 32'(pop_cnt), 32'(HA * VA));
    endtask

    task automatic apply_reset(input int ncyc);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            pix_ce  = 1'(i % 2);
            vga_hs  = 1'($urandom);
            vga_vs  = 1'($urandom);
            vga_rgb = 12'($urandom);
            @(negedge sys_clk);
        end
        sys_rst = 1'b0;
        pix_ce  = 1'b0;
        exp_fc  = '0;
        chk("reset_flags", 32'({pix_valid, frame_start, locked, h_err, v_err}), 32'd0);
        chk("reset_pix", {pix_x, pix_y, pix_rgb}, 32'd0);
        chk("reset_fcnt", 32'(frame_cnt), 32'd0);
        chk("queue_after_reset", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // nlines, short, v0, h0, abort_v, abort_h, fs, lock, verr, const_rgb, irregular
        frame_t tbl[15];
        tbl[0]  = '{VT,     -1, 0, 0, -1, -1, 0, 0, 0, 0, 0};  // boundary 1: SEEK->CHECK
        tbl[1]  = '{VT,     -1, 0, 0, -1, -1, 1, 1, 0, 0, 0};  // boundary 2: lock, frame_cnt=1
        tbl[2]  = '{VT,     -1, 0, 0, -1, -1, 1, 1, 0, 0, 0};  // frame_cnt=2
        tbl[3]  = '{VT,      5, 0, 0, -1, -1, 1, 1, 0, 0, 0};  // short line -> h_err
        tbl[4]  = '{VT,     -1, 0, 0, -1, -1, 0, 0, 0, 0, 0};
        tbl[5]  = '{VT,     -1, 0, 0, -1, -1, 1, 1, 0, 0, 0};  // relock
        tbl[6]  = '{VT - 1, -1, 0, 0, -1, -1, 1, 1, 0, 0, 0};  // short frame
        tbl[7]  = '{VT,     -1, 0, 0, -1, -1, 0, 0, 1, 0, 0};  // v_err at its boundary
        tbl[8]  = '{VT,     -1, 0, 0, -1, -1, 0, 0, 0, 0, 0};
        tbl[9]  = '{VT,     -1, 0, 0, -1, -1, 1, 1, 0, 0, 0};
        tbl[10] = '{VT,     -1, 0, 0, -1, -1, 1, 1, 0, 1, 1};  // irregular gaps, constant rgb
        tbl[11] = '{VT,     -1, 0, 0, -1, -1, 1, 1, 0, 1, 1};
        tbl[12] = '{VT,     -1, 0, 0,  6, 10, 1, 1, 0, 0, 0};  // aborted by reset mid-line
        tbl[13] = '{VT,     -1, 6, 10, -1, -1, 0, 0, 0, 0, 0}; // remainder after reset
        tbl[14] = '{VT,     -1, 0, 0, -1, -1, 0, 0, 0, 0, 0};
        last_exp = '0;
        fork
            monitor_loop();
        join_none
        apply_reset(4);
        mon_en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send_frame(tbl[i]);
            if (i == 12) apply_reset(3);
        end
        send_frame('{VT, -1, 0, 0, -1, -1, 1, 1, 0, 0, 0});  // second boundary after reset relocks
        chk("final_locked", 32'(locked), 32'd1);
        chk("final_fcnt", 32'(frame_cnt), 32'd1);
        repeat (4) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_SYNC 96, hsync width in pixels; H_BACK 48, h back porch; H_ACTIVE 640, visible pixels per line; H_TOTAL 800, pixels per line.
REQ-002 SHALL have parameters: V_SYNC 2, vsync width in lines; V_BACK 33, v back porch; V_ACTIVE 480, visible lines; V_TOTAL 525, lines per frame.
REQ-003 SHALL have ports (name, direction, width, meaning), in this order:
- sys_clk  in  1  system clock, the only clock
- sys_rst  in  1  reset, synchronous, active-high
- pix_ce  in  1  pixel-rate strobe; inputs are sampled only when high
- vga_hs  in  1  hsync, active-low
- vga_vs  in  1  vsync, active-low
- vga_rgb  in  12  RGB444 pixel
- pix_valid  out  1  one-cycle strobe, recovered visible pixel
- pix_x  out  10  column, 0..H_ACTIVE-1
- pix_y  out  10  row, 0..V_ACTIVE-1
- pix_rgb  out  12  captured pixel
- frame_start  out  1  one-cycle pulse at each locked frame boundary
- locked  out  1  timing lock status
- h_err  out  1  one-cycle pulse, bad line length
- v_err  out  1  one-cycle pulse, bad frame length
- frame_cnt  out  16  locked frames seen

Function
REQ-004 SHALL update all internal state only in cycles where pix_ce=1; with pix_ce=0, counters, state and previous-sample registers SHALL hold.
REQ-005 SHALL detect an hs fall as previous sampled vga_hs=1 and current sampled vga_hs=0; vs fall is detected the same way on vga_vs.
REQ-006 SHALL keep an 11-bit h_cnt: 0 on an hs-fall sample, otherwise +1, saturating at 2047.
REQ-007 SHALL, on every hs fall after the first since reset, flag a line error if h_cnt at the previous sample != H_TOTAL-1.
REQ-008 SHALL set an armed flag on a vs fall; on the first hs fall at or after it (the same sample is allowed), treat that sample as a frame boundary, clear armed, and set v_cnt=0.
REQ-009 SHALL otherwise increment the 10-bit v_cnt on each hs fall, saturating at 1023.
REQ-010 SHALL, at each frame boundary, flag a frame error if v_cnt before the boundary != V_TOTAL-1 (checked only in states CHECK and LOCKED).
REQ-011 SHALL implement FSM states SEEK (reset state), CHECK and LOCKED.
- SEEK: frame boundary -> CHECK.
- CHECK: line error -> SEEK; frame boundary with frame error -> SEEK; frame boundary with no error -> LOCKED.
- LOCKED: line error or frame error -> SEEK.
REQ-012 SHALL pulse h_err for line errors and v_err for frame errors only in states CHECK and LOCKED; both may pulse in the same cycle.
REQ-013 SHALL define a visible sample as state LOCKED, H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE, and V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE.
- h_cnt and v_cnt here are the values assigned on that sample.
REQ-014 SHALL, for each visible sample, pulse pix_valid in the following sys_clk cycle.
- pix_x = h_cnt-(H_SYNC+H_BACK); pix_y = v_cnt-(V_SYNC+V_BACK); pix_rgb = vga_rgb sampled on that pix_ce cycle.
- Latency is 1 cycle.
REQ-015 SHALL hold pix_x, pix_y and pix_rgb when pix_valid=0.
REQ-016 SHALL pulse frame_start one cycle after a frame boundary that leaves the FSM in LOCKED (including the CHECK->LOCKED transition), and increment frame_cnt in the same cycle; frame_cnt wraps 0xFFFF->0x0000.
REQ-017 SHALL drive locked high exactly while state is LOCKED, registered with the same 1-cycle latency as pix_valid.
REQ-018 SHALL, on the cycle that leaves LOCKED, suppress pix_valid for that sample.

Reset
REQ-019 SHALL, when sys_rst=1 at a rising edge, regardless of pix_ce:
- set state to SEEK, h_cnt=0, v_cnt=0, armed=0;
- set previous hs/vs samples to 1;
- force all outputs to 0 (pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked, h_err, v_err, frame_cnt).
REQ-020 SHALL, when reset is asserted mid-frame, discard the partial frame; the first line after reset SHALL NOT raise h_err.

Verification
REQ-021 Reset: assert sys_rst 4 cycles with pix_ce toggling -> all outputs 0, state SEEK.
REQ-022 Nominal 640x480 timing with pix_ce every 4th cycle, 3 frames -> locked rises 1 cycle after the 2nd frame boundary; frame 3 yields 307200 pix_valid pulses; first is x=0,y=0 (h_cnt=144, v_cnt=35); last is x=639,y=479; frame_cnt=1 then 2.
REQ-023 While locked, shorten one line to 799 pixels -> h_err pulse, locked falls, no pix_valid until relock two frame boundaries later; v_err stays 0.
REQ-024 While locked, send a 524-line frame -> v_err pulse at the boundary, locked=0, frame_start not pulsed for that boundary.
REQ-025 Irregular pix_ce gaps (1-7 idle cycles) with a constant pattern vga_rgb=12'hA5C -> same pix_x/pix_y sequence as REQ-022, pix_rgb=12'hA5C, no errors.
REQ-026 sys_rst pulsed mid-line during frame 3 -> outputs 0 next cycle; lock regained after two further boundaries, with no h_err on the first post-reset line.
